// File: rtl/uart_pkg.sv
// Constants and types shared by the UART receive path (baud generator, receiver, rx FIFO).
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam logic [10:0] DVSR_9600_100MHZ = 11'd651;
  typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and overflow bookkeeping for the uart_rx FIFO.
// Flags depend only on the registered count, never directly on wr or rd.
module fifo_ctrl #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic              clr_overflow,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] r_addr,
  output logic              w_en,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

  logic do_wr;
  logic do_rd;

  assign empty = (count == '0);
  assign full  = (count == DEPTH);
  assign do_rd = rd & ~empty;
  // A pop in the same cycle frees the slot, so a write while full still lands.
  assign do_wr = wr & (~full | rd);
  assign w_en  = do_wr & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      w_addr   <= '0;
      r_addr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) w_addr <= w_addr + 1'b1;
      if (do_rd) r_addr <= r_addr + 1'b1;
      if (do_wr && !do_rd)
        count <= count + 1'b1;
      else if (do_rd && !do_wr)
        count <= count - 1'b1;
      // A dropped write takes priority over a clear in the same cycle.
      if (wr && full && !rd)
        overflow <= 1'b1;
      else if (clr_overflow)
        overflow <= 1'b0;
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte buffer behind uart_rx; r_data shows the head entry
// combinationally whenever empty is low.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rd,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_overflow
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_addr;
  logic              w_en;

  fifo_ctrl #(.ADDR_W(ADDR_W)) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .rd           (rd),
    .clr_overflow (clr_overflow),
    .w_addr       (w_addr),
    .r_addr       (r_addr),
    .w_en         (w_en),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow)
  );

  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic       rd = 1'b0;
  logic       clr_overflow = 1'b0;
  logic [7:0] r_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  bit         m_ovf = 1'b0;

  uart_rx_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .w_data       (w_data),
    .rd           (rd),
    .r_data       (r_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO is a queue of at most 16 bytes.
  task automatic model_update(input bit i_wr, input logic [7:0] i_d, input bit i_rd,
                              input bit i_clr, input bit i_rst);
    int  n;
    bit  pop;
    bit  push;
    if (i_rst) begin
      q.delete();
      m_ovf = 1'b0;
      return;
    end
    n    = q.size();
    pop  = i_rd && (n > 0);
    push = i_wr && ((n < 16) || i_rd);
    if (i_wr && !push) m_ovf = 1'b1;
    else if (i_clr)    m_ovf = 1'b0;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(i_d);
  endtask

  task automatic compare_model();
    chk("model_count", 32'(count), 32'(q.size()));
    chk("model_empty", 32'(empty), 32'(q.size() == 0));
    chk("model_full", 32'(full), 32'(q.size() == 16));
    chk("model_overflow", 32'(overflow), 32'(m_ovf));
    if (q.size() > 0) chk("model_r_data", 32'(r_data), 32'(q[0]));
  endtask

  task automatic step(input bit i_wr, input logic [7:0] i_d, input bit i_rd,
                      input bit i_clr, input bit i_rst);
    wr = i_wr; w_data = i_d; rd = i_rd; clr_overflow = i_clr; reset = i_rst;
    @(posedge clk);
    model_update(i_wr, i_d, i_rd, i_clr, i_rst);
    #1;
    wr = 1'b0; rd = 1'b0; clr_overflow = 1'b0; reset = 1'b0;
    compare_model();
  endtask

  task automatic push_b(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_b();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int pw;
    int pr;
    #2;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);

    // 1: single write and pop
    push_b(8'h55);
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_empty", 32'(empty), 32'd0);
    chk("t1_data", 32'(r_data), 32'h55);
    pop_b();
    chk("t1_pop_empty", 32'(empty), 32'd1);
    chk("t1_pop_count", 32'(count), 32'd0);

    // 2: fill, overflow, drain in order
    for (int i = 0; i < 16; i++) push_b(8'(i));
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_count", 32'(count), 32'd16);
    push_b(8'hAA);
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_count_drop", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("t2_drain", 32'(r_data), 32'(i));
      pop_b();
    end
    chk("t2_empty", 32'(empty), 32'd1);

    // 3: simultaneous wr/rd while full
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t3_ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) push_b(8'(i));
    step(1'b1, 8'hBB, 1'b1, 1'b0, 1'b0);
    chk("t3_count", 32'(count), 32'd16);
    chk("t3_ovf", 32'(overflow), 32'd0);
    chk("t3_head", 32'(r_data), 32'h01);
    for (int i = 1; i < 16; i++) pop_b();
    chk("t3_last", 32'(r_data), 32'hBB);
    pop_b();

    // 4: simultaneous wr/rd while empty; rd while empty
    step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    chk("t4_count", 32'(count), 32'd1);
    chk("t4_data", 32'(r_data), 32'h33);
    pop_b();
    pop_b();
    chk("t4_empty_rd", 32'(count), 32'd0);
    push_b(8'h44);
    chk("t4_after", 32'(r_data), 32'h44);
    pop_b();

    // 5: pointer wrap
    for (int i = 0; i < 10; i++) push_b(8'(8'h10 + i));
    for (int i = 0; i < 10; i++) pop_b();
    for (int i = 0; i < 12; i++) push_b(8'(8'h80 + i));
    chk("t5_count", 32'(count), 32'd12);
    for (int i = 0; i < 12; i++) begin
      chk("t5_wrap", 32'(r_data), 32'(8'h80 + i));
      pop_b();
    end

    // 6: set-wins on overflow, clear, reset mid-operation
    for (int i = 0; i < 16; i++) push_b(8'(8'hC0 + i));
    push_b(8'hEE);
    step(1'b1, 8'hEF, 1'b0, 1'b1, 1'b0);
    chk("t6_set_wins", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t6_clr", 32'(overflow), 32'd0);
    push_b(8'hEE);
    for (int i = 0; i < 11; i++) pop_b();
    chk("t6_count5", 32'(count), 32'd5);
    chk("t6_ovf_set", 32'(overflow), 32'd1);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_empty", 32'(empty), 32'd1);
    chk("t6_rst_ovf", 32'(overflow), 32'd0);

    // 7: two received bytes as uart_rx would deliver them
    push_b(8'h55);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    push_b(8'hFF);
    chk("t7_count", 32'(count), 32'd2);
    chk("t7_head", 32'(r_data), 32'h55);
    pop_b();
    chk("t7_next", 32'(r_data), 32'hFF);
    pop_b();

    // Randomized traffic with shifting write/read pressure
    pw = 50; pr = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        pw = $urandom_range(90, 10);
        pr = $urandom_range(90, 10);
      end
      step($urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < pr,
           $urandom_range(99) < 5, $urandom_range(999) < 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
